moving_average_filter: RTL

- Streaming moving-average (boxcar) low-pass stage that sits directly downstream of the 16-bit adder datapath.
- Keeps a running sum of the last 2^LOG2_TAPS unsigned samples in a circular delay buffer.
- Update per sample: sum = sum + new - oldest, done as sequential ADD then SUB steps on one 16-bit add/subtract path.
- Emits sum >> LOG2_TAPS over a valid/ready handshake to the next filter stage.

---
 rtl/moving_average_filter.sv | 128 ++++++++++++
 1 files changed

// File: rtl/moving_average_filter.sv
// Streaming boxcar moving-average filter over the last 2^LOG2_TAPS unsigned samples.
// Build option: define MAVG_ROUND_EN for round-half-up output instead of truncation.
module moving_average_filter #(
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned LOG2_TAPS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int unsigned TAPS  = 1 << LOG2_TAPS;
    localparam int unsigned ACC_W = DATA_W + LOG2_TAPS;

    typedef enum logic [2:0] {
        CLR,
        IDLE,
        ADD,
        SUB,
        OUT
    } state_t;

    state_t               state;
    logic [LOG2_TAPS-1:0] clr_cnt;
    logic [LOG2_TAPS-1:0] wr_ptr;
    logic [ACC_W-1:0]     acc;
    logic [ACC_W-1:0]     acc_nxt;
    logic [DATA_W-1:0]    sample_q;
    logic [DATA_W-1:0]    oldest_q;
    logic [DATA_W-1:0]    operand;
    logic [DATA_W-1:0]    avg;
    logic [DATA_W-1:0]    window [TAPS];

    assign in_ready = (state == IDLE) && !flush;

    // One shared add/subtract path: ADD adds the new sample, SUB removes the oldest.
    always_comb begin
        operand = (state == SUB) ? oldest_q : sample_q;
        if (state == SUB)
            acc_nxt = acc - {{LOG2_TAPS{1'b0}}, operand};
        else
            acc_nxt = acc + {{LOG2_TAPS{1'b0}}, operand};
    end

`ifdef MAVG_ROUND_EN
    localparam int unsigned HALF = TAPS / 2;
    logic [ACC_W:0] acc_rnd;
    logic           unused_rnd_bits;

    always_comb begin
        acc_rnd         = {1'b0, acc_nxt} + HALF[ACC_W:0];
        avg             = acc_rnd[LOG2_TAPS +: DATA_W];
        unused_rnd_bits = ^{acc_rnd[ACC_W], acc_rnd[LOG2_TAPS-1:0]};
    end
`else
    always_comb begin
        avg = acc_nxt[ACC_W-1:LOG2_TAPS];
    end
`endif

    // Window storage has no reset so it can map onto RAM; CLR zeroes it instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLR)
                window[clr_cnt] <= '0;
            else if (state == SUB)
                window[wr_ptr] <= sample_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= CLR;
            clr_cnt   <= '0;
            wr_ptr    <= '0;
            acc       <= '0;
            sample_q  <= '0;
            oldest_q  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                CLR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == '1)
                        state <= IDLE;
                end
                IDLE: begin
                    if (flush) begin
                        state   <= CLR;
                        clr_cnt <= '0;
                        wr_ptr  <= '0;
                        acc     <= '0;
                    end else if (in_valid) begin
                        sample_q <= in_data;
                        oldest_q <= window[wr_ptr];
                        state    <= ADD;
                    end
                end
                ADD: begin
                    acc   <= acc_nxt;
                    state <= SUB;
                end
                SUB: begin
                    acc       <= acc_nxt;
                    wr_ptr    <= wr_ptr + 1'b1;
                    out_data  <= avg;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= CLR;
            endcase
        end
    end

endmodule
